// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-drive and response signals of alu_share_arbiter.
// The slave modport is the arbiter; the master modport is the requesters, ALU and consumer.
interface alu_share_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_op;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_srca, alu_srcb, alu_control,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_srca, alu_srcb, alu_control,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between two requesters: arbitrate, drive the ALU from
// registers, capture the result and hand it back tagged with the requester ID.
module alu_share_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_id;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [2:0]  r_op_code;
  logic [31:0] r_rsp_result;
  logic        r_rsp_zero;
  logic        r_rsp_err;
  logic        r_rsp_valid;

  logic        w_accept;
  logic        w_grant;
  logic        w_op_legal;

  // On a tie round-robin hands the ALU to whoever did not win last time.
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = FIXED_PRIO ? 1'b0 : ~r_last_grant;
    end else begin
      w_grant = bus.req1_valid;
    end
  end

  always_comb begin
    w_op_legal = 1'b0;
    case (r_op_code)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: w_op_legal = 1'b1;
      default:                                w_op_legal = 1'b0;
    endcase
  end

  assign w_accept       = (r_state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = w_accept && !w_grant;
  assign bus.req1_ready = w_accept && w_grant;

  assign bus.alu_srca    = r_op_a;
  assign bus.alu_srcb    = r_op_b;
  assign bus.alu_control = r_op_code;

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_err    = r_rsp_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_code    <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a       <= w_grant ? bus.req1_a  : bus.req0_a;
            r_op_b       <= w_grant ? bus.req1_b  : bus.req0_b;
            r_op_code    <= w_grant ? bus.req1_op : bus.req0_op;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_op_legal) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_zero   <= bus.alu_zero;
            r_rsp_err    <= 1'b0;
          end else begin
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b1;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_alu_share_arbiter;

  logic clk;
  logic reset;

  alu_share_arbiter_if bus0 ();
  alu_share_arbiter_if bus1 ();

  alu_share_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .reset(reset), .bus(bus0));
  alu_share_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; illegal codes return a junk pattern the arbiter must not forward.
  function automatic logic [31:0] alu_eval(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus0.alu_result = alu_eval(bus0.alu_control, bus0.alu_srca, bus0.alu_srcb);
  assign bus0.alu_zero   = (bus0.alu_result == 32'd0);
  assign bus1.alu_result = alu_eval(bus1.alu_control, bus1.alu_srca, bus1.alu_srcb);
  assign bus1.alu_zero   = (bus1.alu_result == 32'd0);

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Requester model: what each side currently holds valid, plus last winner.
  bit          pend_v [2];
  logic [31:0] pend_a [2];
  logic [31:0] pend_b [2];
  logic [2:0]  pend_op[2];
  bit          m_last;

  task automatic drive_reqs();
    bus0.req0_valid = pend_v[0];
    bus0.req0_a     = pend_a[0];
    bus0.req0_b     = pend_b[0];
    bus0.req0_op    = pend_op[0];
    bus0.req1_valid = pend_v[1];
    bus0.req1_a     = pend_a[1];
    bus0.req1_b     = pend_b[1];
    bus0.req1_op    = pend_op[1];
  endtask

  task automatic set_pend(input bit id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
    pend_v[id]  = 1'b1;
    pend_a[id]  = a;
    pend_b[id]  = b;
    pend_op[id] = op;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    drive_reqs();
    bus0.rsp_ready = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    m_last = 1'b1;
  endtask

  // One transaction on bus0; starts and ends just after a falling edge.
  task automatic run_txn(input bit eg, input logic [31:0] er, input bit ez, input bit ee,
                         input int unsigned bp);
    logic [31:0] acc_a, acc_b;
    logic [2:0]  acc_op;
    drive_reqs();
    #1;
    check("grant", {bus0.req1_ready, bus0.req0_ready}, eg ? 2'b10 : 2'b01);
    acc_a  = pend_a[eg];
    acc_b  = pend_b[eg];
    acc_op = pend_op[eg];
    @(posedge clk);
    #1;
    pend_v[eg] = 1'b0;
    m_last     = eg;
    drive_reqs();
    @(negedge clk);
    bus0.rsp_ready = 1'($urandom_range(0, 1));
    check("exec_idle", {bus0.rsp_valid, bus0.req1_ready, bus0.req0_ready}, 3'b000);
    check("alu_drive", {bus0.alu_srca, bus0.alu_srcb, bus0.alu_control}, {acc_a, acc_b, acc_op});
    @(negedge clk);
    bus0.rsp_ready = (bp == 0);
    check("rsp", {bus0.rsp_valid, bus0.rsp_id, bus0.rsp_err, bus0.rsp_zero, bus0.rsp_result},
          {1'b1, eg, ee, ez, er});
    for (int unsigned i = 1; i <= bp; i++) begin
      @(negedge clk);
      check("rsp_hold", {bus0.rsp_valid, bus0.rsp_id, bus0.rsp_err, bus0.rsp_zero,
                         bus0.rsp_result, bus0.req1_ready, bus0.req0_ready},
            {1'b1, eg, ee, ez, er, 2'b00});
      if (i == bp) bus0.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    bus0.rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_drop", bus0.rsp_valid, 1'b0);
  endtask

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    bit          z;
    bit          e;
  } vec_t;

  vec_t vecs[13];

  initial begin
    bit          eg;
    logic [31:0] er;
    bit          legal;

    vecs[0]  = '{1'b0, 32'd5,         32'd7,         3'b000, 32'd12,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'd9,         32'd9,         3'b001, 32'd0,         1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'd3,         32'd8,         3'b101, 32'd1,         1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 32'h00F0_00F0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 32'hFFF0_FFF0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 3'b110, 32'd0,         1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'd1,         32'd1,         3'b000, 32'd2,         1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'd0,         32'd1,         3'b001, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         3'b101, 32'd0,         1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'd1,         32'hFFFF_FFFF, 3'b101, 32'd1,         1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'd7,         32'd3,         3'b100, 32'd0,         1'b0, 1'b1};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         3'b000, 32'd0,         1'b1, 1'b0};
    vecs[12] = '{1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 3'b111, 32'd0,         1'b0, 1'b1};

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pend_v[i] = 1'b0; pend_a[i] = '0; pend_b[i] = '0; pend_op[i] = '0;
    end
    m_last = 1'b1;
    drive_reqs();
    bus0.rsp_ready  = 1'b0;
    bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_op = '0;
    bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_op = '0;
    bus1.rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", {bus0.req1_ready, bus0.req0_ready}, 2'b00);
    check("rst_alu", {bus0.alu_srca, bus0.alu_srcb, bus0.alu_control}, 67'd0);
    check("rst_rsp", {bus0.rsp_valid, bus0.rsp_id, bus0.rsp_err, bus0.rsp_zero,
                      bus0.rsp_result}, 36'd0);
    @(negedge clk);

    // Directed vector table, one requester at a time.
    for (int i = 0; i < 13; i++) begin
      set_pend(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      run_txn(vecs[i].id, vecs[i].res, vecs[i].z, vecs[i].e, 32'(i % 3));
    end

    // Back-pressure with req1 waiting behind a stalled response.
    apply_reset();
    set_pend(1'b0, 32'd100, 32'd23, 3'b000);
    set_pend(1'b1, 32'd50,  32'd8,  3'b001);
    run_txn(1'b0, 32'd123, 1'b0, 1'b0, 10);
    run_txn(1'b1, 32'd42,  1'b0, 1'b0, 0);

    // Round-robin with both requesters held valid.
    apply_reset();
    set_pend(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010);
    set_pend(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011);
    for (int k = 0; k < 4; k++) begin
      eg = 1'(k % 2);
      run_txn(eg, eg ? 32'hFFF0_FFF0 : 32'h00F0_00F0, 1'b0, 1'b0, 0);
      set_pend(eg, 32'hF0F0_F0F0, 32'h0FF0_0FF0, eg ? 3'b011 : 3'b010);
    end
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    drive_reqs();

    // Fixed priority: requester 0 wins every tie.
    bus1.req0_valid = 1'b1; bus1.req0_a = 32'hF0F0_F0F0; bus1.req0_b = 32'h0FF0_0FF0;
    bus1.req0_op    = 3'b010;
    bus1.req1_valid = 1'b1; bus1.req1_a = 32'hF0F0_F0F0; bus1.req1_b = 32'h0FF0_0FF0;
    bus1.req1_op    = 3'b011;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fp_grant", {bus1.req1_ready, bus1.req0_ready}, 2'b01);
      @(negedge clk);
      check("fp_exec", {bus1.rsp_valid, bus1.req1_ready, bus1.req0_ready}, 3'b000);
      @(negedge clk);
      check("fp_rsp", {bus1.rsp_valid, bus1.rsp_id, bus1.rsp_err, bus1.rsp_result},
            {1'b1, 1'b0, 1'b0, 32'h00F0_00F0});
      @(negedge clk);
    end
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;

    // Asynchronous reset in the middle of EXEC discards the operation.
    set_pend(1'b0, 32'd2, 32'd3, 3'b000);
    drive_reqs();
    #1;
    check("mid_grant", {bus0.req1_ready, bus0.req0_ready}, 2'b01);
    @(posedge clk);
    #1;
    pend_v[0] = 1'b0;
    drive_reqs();
    bus0.rsp_ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_rsp", {bus0.rsp_valid, bus0.rsp_result, bus0.rsp_id}, 34'd0);
    check("mid_rst_alu", {bus0.alu_srca, bus0.alu_srcb, bus0.alu_control}, 67'd0);
    @(negedge clk);
    reset  = 1'b0;
    m_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_stale", {bus0.rsp_valid, bus0.req1_ready, bus0.req0_ready}, 3'b000);
    end
    bus0.rsp_ready = 1'b0;

    // Randomized traffic against the transaction-level model.
    for (int t = 0; t < 60; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend_v[r] && ($urandom_range(0, 1) == 1)) begin
          pend_a[r]  = $urandom;
          pend_b[r]  = ($urandom_range(0, 3) == 0) ? pend_a[r] : $urandom;
          pend_op[r] = 3'($urandom_range(0, 7));
          pend_v[r]  = 1'b1;
        end
      end
      if (!pend_v[0] && !pend_v[1]) set_pend(1'($urandom_range(0, 1)), $urandom, $urandom, 3'b000);
      eg = (pend_v[0] && pend_v[1]) ? ~m_last : pend_v[1];
      case (pend_op[eg])
        3'b000, 3'b001, 3'b010, 3'b011, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
      er = legal ? alu_eval(pend_op[eg], pend_a[eg], pend_b[eg]) : 32'd0;
      run_txn(eg, er, legal && (er == 32'd0), !legal, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter and sequencer that shares the single 32-bit datapath ALU between two requesters, e.g. the core pipeline and a debug/CSR helper. It accepts one operation at a time over a valid/ready handshake, chooses between simultaneous requests round-robin, drives the ALU operands and control from registers, and captures the result. It returns the result tagged with the requester ID through a held response handshake. It sits between the requesters and the ALU in the datapath; the ALU itself is unchanged.

## Interface
- FIXED_PRIO, default 0: 0 selects round-robin; 1 means requester 0 always wins a tie.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req0_valid / req1_valid  in  1  requester N has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle (combinational).
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- req0_op / req1_op  in  3  ALU control code.
- alu_srca, alu_srcb  out  32  to ALU SrcA/SrcB.
- alu_control  out  3  to ALU ALUControl.
- alu_result  in  32  from ALU ALUResult.
- alu_zero  in  1  from ALU Zero.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester the response belongs to.
- rsp_result  out  32  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  the op code was illegal.

## Operation
- Legal op codes: 000 add, 001 sub, 010 and, 011 or, 101 set-less-than (unsigned). Codes 100, 110 and 111 are illegal.
- The FSM has three states: IDLE, EXEC and RESP.
  - IDLE: if any reqN_valid is high, compute grant g.
    - Assert req{g}_ready combinationally for this cycle only.
    - At the edge, latch the operands and op into op_a, op_b, op_code, and latch id=g.
    - Update last_grant=g and go to EXEC.
  - EXEC: wait for the registered ALU inputs to settle.
    - For a legal op, latch alu_result into rsp_result, alu_zero into rsp_zero, and set rsp_err=0.
    - For an illegal op, set rsp_result=0, rsp_zero=0, rsp_err=1.
    - Go to RESP.
  - RESP: assert rsp_valid. Response fields hold stable until the rsp_valid && rsp_ready edge, then return to IDLE.
- ALU drive: alu_srca=op_a, alu_srcb=op_b and alu_control=op_code come straight from registers. They hold their last values in every state, so the ALU output never depends on live request inputs.
- Grant rules:
  - Only one valid: that requester is granted.
  - Both valid with FIXED_PRIO=1: requester 0 is granted.
  - Both valid with FIXED_PRIO=0: the requester other than last_grant is granted.
- Both ready outputs are 0 outside IDLE. At most one ready is high in any cycle.
- Requester rule: once reqN_valid is raised, valid, operands and op stay stable until reqN_ready. The block does not tolerate withdrawal.
- Reset values:
  - State is IDLE and last_grant=1, so requester 0 wins the first tie.
  - op_a, op_b, op_code, rsp_result and rsp_id are 0.
  - rsp_zero, rsp_err, rsp_valid and both ready outputs are 0.
  - alu_srca, alu_srcb and alu_control are 0 (add 0+0).
- Reset mid-operation: an in-flight or unconsumed response is discarded. The block does not restart or replay it.

## Timing
- Latency: accept edge at cycle T (ready high in T), EXEC in T+1, rsp_valid high from T+2.
- Back-pressure: rsp_valid stays high and rsp_* stay stable for as long as rsp_ready=0.
- Throughput: with rsp_ready tied high, the block handles one operation per 3 cycles. The next accept can happen in the cycle after the response handshake.
- Requests raised while the block is busy wait. They are arbitrated on the first IDLE cycle.
- rsp_ready while rsp_valid=0 is ignored.

## Test plan
- Reset: after reset deasserts, every output is 0 and the state is IDLE. Assert reset asynchronously mid-EXEC; rsp_valid drops to 0 immediately and no stale response appears afterwards.
- Single add: req0 with a=5, b=7, op=000 and rsp_ready=1. req0_ready pulses in cycle T, rsp_valid in T+2 with rsp_result=12, rsp_id=0, rsp_zero=0, rsp_err=0.
- Sub zero and slt: req1 with a=9, b=9, op=001 returns result 0, zero=1, id=1. Then a=3, b=8, op=101 returns result 1, zero=0.
- Round-robin, FIXED_PRIO=0: both requesters held valid (req0 and a=0xF0F0_F0F0, b=0x0FF0_0FF0, op=010; req1 or, same operands) for 4 operations. Grants go 0,1,0,1 with results 0x00F0_00F0 / 0xFFF0_FFF0. FIXED_PRIO=1 gives grants 0,0,0,0 while req0 stays valid.
- Back-pressure: rsp_ready=0 for 10 cycles after the response appears. rsp_valid and rsp_result hold, no ready is asserted, and a pending req1 is accepted only in the cycle after the rsp_ready handshake.
- Illegal op: req0 op=110 returns rsp_err=1, rsp_result=0, rsp_zero=0. The next legal op, add 1+1, returns 2 with err=0.
